// File: rtl/mulu_x2y2_if.sv
// Operand/product bundle for mulu_x2y2; the optional sign flag s exists only when MULU_SIGN_EN is defined.
interface mulu_x2y2_if #(
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2,
  parameter int P_WIDTH = X_WIDTH + Y_WIDTH
);
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic [P_WIDTH-1:0] p;
  logic               rdy;
`ifdef MULU_SIGN_EN
  logic               s;

  modport master (output x, output y, input p, input rdy, input s);
  modport slave  (input x, input y, output p, output rdy, output s);
`else
  modport master (output x, output y, input p, input rdy);
  modport slave  (input x, input y, output p, output rdy);
`endif
endinterface

// File: rtl/mulu_x2y2.sv
// Unsigned X_WIDTH x Y_WIDTH array multiplier (AND partial products, ripple adder rows) with one output register.
// Optional feature macro: MULU_SIGN_EN adds the registered two's-complement sign flag s.
module mulu_x2y2 #(
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2,
  parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  mulu_x2y2_if.slave  bus
);

  logic [Y_WIDTH-1:0][X_WIDTH-1:0] pp;
  logic [Y_WIDTH-1:0][P_WIDTH-1:0] acc;
  logic [P_WIDTH-1:0]              prod;

  // Row i of the array adds pp[i] << i onto the running sum with a carry-ripple chain.
  always_comb begin
    logic [P_WIDTH-1:0] addend;
    logic               carry;
    // NOTE: every variable gets a default first so no path through the block can infer a latch.
    pp     = '0;
    acc    = '0;
    addend = '0;
    carry  = 1'b0;
    for (int i = 0; i < Y_WIDTH; i++) begin
      for (int j = 0; j < X_WIDTH; j++) begin
        pp[i][j] = bus.x[j] & bus.y[i];
      end
    end
    acc[0] = {{(P_WIDTH-X_WIDTH){1'b0}}, pp[0]};
    for (int i = 1; i < Y_WIDTH; i++) begin
      addend = P_WIDTH'(pp[i]) << i;
      carry  = 1'b0;
      // NOTE: blocking assignments here are intentional; carry must ripple bit to bit within one evaluation.
      for (int k = 0; k < P_WIDTH; k++) begin
        acc[i][k] = acc[i-1][k] ^ addend[k] ^ carry;
        carry     = (acc[i-1][k] & addend[k]) | (carry & (acc[i-1][k] ^ addend[k]));
      end
    end
    prod = acc[Y_WIDTH-1];
  end

  // NOTE: the output register is reset synchronously; rst is only seen on a rising clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.p   <= '0;
      bus.rdy <= 1'b0;
`ifdef MULU_SIGN_EN
      bus.s   <= 1'b0;
`endif
    end else begin
      bus.p   <= prod;
      bus.rdy <= 1'b1;
`ifdef MULU_SIGN_EN
      bus.s   <= (bus.x[X_WIDTH-1] ^ bus.y[Y_WIDTH-1]) & (prod != '0);
`endif
    end
  end

endmodule

// File: tb/tb_mulu_x2y2.sv
// Self-checking bench for mulu_x2y2: directed reset/sweep/back-to-back cases plus random pairs against an arithmetic model.
module tb_mulu_x2y2;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int PW = XW + YW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  mulu_x2y2_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .P_WIDTH(PW)) bus ();

  mulu_x2y2 #(.X_WIDTH(XW), .Y_WIDTH(YW), .P_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Signed reading of an operand, used only for the optional sign flag.
  function automatic int as_signed(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  // Apply one operand pair for one edge, then compare against the product rules.
  task automatic step(input string tag, input bit r, input int xv, input int yv);
    int exp_p;
    int exp_rdy;
    rst   = r;
    bus.x = XW'(xv);
    bus.y = YW'(yv);
    exp_p   = r ? 0 : xv * yv;
    exp_rdy = r ? 0 : 1;
    @(posedge clk);
    #1;
    check({tag, ".p"}, 32'(bus.p), 32'(exp_p));
    check({tag, ".rdy"}, 32'(bus.rdy), 32'(exp_rdy));
`ifdef MULU_SIGN_EN
    check({tag, ".s"}, 32'(bus.s),
          32'((!r && as_signed(xv, XW) * as_signed(yv, YW) < 0) ? 1 : 0));
`endif
  endtask

  initial begin
    bus.x = '0;
    bus.y = '0;
    #2;

    // Reset held for two edges with live operands, then first product.
    step("rst0", 1'b1, 3, 3);
    step("rst1", 1'b1, 3, 3);
    step("first", 1'b0, 3, 3);

    // Exhaustive sweep, one pair per cycle.
    for (int xi = 0; xi < (1 << XW); xi++) begin
      for (int yi = 0; yi < (1 << YW); yi++) begin
        step($sformatf("sweep_%0dx%0d", xi, yi), 1'b0, xi, yi);
      end
    end

    // Back-to-back operands.
    step("b2b_9", 1'b0, 3, 3);
    step("b2b_4", 1'b0, 2, 2);

    // Reset for one edge mid-stream, then recovery.
    step("mid_rst", 1'b1, 3, 2);
    step("mid_rec", 1'b0, 3, 2);

    // X on inputs during reset must stay out of the outputs.
    rst   = 1'b1;
    bus.x = 'x;
    bus.y = 'x;
    @(posedge clk);
    #1;
    check("xrst.p", 32'(bus.p), 32'd0);
    check("xrst.rdy", 32'(bus.rdy), 32'd0);
    step("xrec", 1'b0, 1, 3);

`ifdef MULU_SIGN_EN
    step("sgn_2x1", 1'b0, 2, 1);
    step("sgn_3x3", 1'b0, 3, 3);
    step("sgn_2x0", 1'b0, 2, 0);
`endif

    // Random pairs with occasional resets.
    for (int n = 0; n < 60; n++) begin
      step($sformatf("rnd%0d", n), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, (1 << XW) - 1)), int'($urandom_range(0, (1 << YW) - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
